// File: rtl/wqe_cache_reader.sv
// Read-side engine for the dual-queue WQE cache: pops WQEs, absorbs the 1-cycle
// read latency and hands them to the TX packetizer through a 2-entry output FIFO.
module wqe_cache_reader #(
    parameter int WQE_WIDTH    = 512,
    parameter int QP_PTR_WIDTH = 4,
    parameter int WQE_QPID_LSB = 328,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    i_en,
    input  logic                    i_wqe_cache_empty,
    output logic                    o_wqe_cache_rd,
    input  logic                    i_wqe_val,
    input  logic [WQE_WIDTH-1:0]    i_wqe,
    output logic                    o_wqe_val,
    input  logic                    i_wqe_rdy,
    output logic [WQE_WIDTH-1:0]    o_wqe,
    output logic [QP_PTR_WIDTH-1:0] o_wqe_qpn,
    output logic [63:0]             o_wqe_wrid,
    output logic                    o_idle,
    output logic [CNT_WIDTH-1:0]    o_dispatch_cnt,
    output logic [1:0]              o_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [1:0]           occ;
    logic                 pend;
    logic [WQE_WIDTH-1:0] head_q;
    logic [WQE_WIDTH-1:0] tail_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [1:0]           err_q;
    logic                 pop;
    logic                 push;
    logic [2:0]           committed;

    assign o_wqe_val  = (occ != 2'd0);
    assign pop        = o_wqe_val & i_wqe_rdy;
    assign push       = i_wqe_val & pend;

    // Slots already owned (buffered + in flight) after this cycle's pop; keeping
    // this below 2 guarantees a returning WQE always has room in the FIFO.
    assign committed  = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};

    assign o_wqe_cache_rd = (state == ST_RUN) & i_en & ~i_wqe_cache_empty
                            & (committed < 3'd2);

    assign o_wqe          = head_q;
    assign o_wqe_qpn      = head_q[WQE_QPID_LSB +: QP_PTR_WIDTH];
    assign o_wqe_wrid     = head_q[63:0];
    assign o_idle         = (state == ST_IDLE);
    assign o_dispatch_cnt = cnt_q;
    assign o_err          = err_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_en) state_nxt = ST_RUN;
            ST_RUN:   if (!i_en) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (i_en)
                    state_nxt = ST_RUN;
                else if (!pend && (occ == 2'd0))
                    state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_IDLE;
            pend  <= 1'b0;
            cnt_q <= '0;
            err_q <= 2'b00;
        end else begin
            state <= state_nxt;
            pend  <= o_wqe_cache_rd;
            if (pop)
                cnt_q <= cnt_q + 1'b1;
            if (i_wqe_val && !pend)
                err_q[0] <= 1'b1;
            if (pend && !i_wqe_val)
                err_q[1] <= 1'b1;
        end
    end

    // Head is registered so o_wqe never depends on the cache read data path.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            occ    <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0)
                        head_q <= i_wqe;
                    else
                        tail_q <= i_wqe;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd2)
                        head_q <= tail_q;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_q <= i_wqe;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= i_wqe;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wqe_cache_reader.sv
// Self-checking bench for wqe_cache_reader: a queue-based cache and reference
// model are stepped once per clock and compared against every DUT output.
module tb_wqe_cache_reader;

    localparam int W    = 512;
    localparam int QPW  = 4;
    localparam int QLSB = 328;
    localparam int CW   = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic           sys_clk;
    logic           sys_rst;
    logic           i_en;
    logic           i_wqe_cache_empty;
    logic           o_wqe_cache_rd;
    logic           i_wqe_val;
    logic [W-1:0]   i_wqe;
    logic           o_wqe_val;
    logic           i_wqe_rdy;
    logic [W-1:0]   o_wqe;
    logic [QPW-1:0] o_wqe_qpn;
    logic [63:0]    o_wqe_wrid;
    logic           o_idle;
    logic [CW-1:0]  o_dispatch_cnt;
    logic [1:0]     o_err;

    wqe_cache_reader #(
        .WQE_WIDTH   (W),
        .QP_PTR_WIDTH(QPW),
        .WQE_QPID_LSB(QLSB),
        .CNT_WIDTH   (CW)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .i_en             (i_en),
        .i_wqe_cache_empty(i_wqe_cache_empty),
        .o_wqe_cache_rd   (o_wqe_cache_rd),
        .i_wqe_val        (i_wqe_val),
        .i_wqe            (i_wqe),
        .o_wqe_val        (o_wqe_val),
        .i_wqe_rdy        (i_wqe_rdy),
        .o_wqe            (o_wqe),
        .o_wqe_qpn        (o_wqe_qpn),
        .o_wqe_wrid       (o_wqe_wrid),
        .o_idle           (o_idle),
        .o_dispatch_cnt   (o_dispatch_cnt),
        .o_err            (o_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int           vectors;
    int           miscompares;
    logic [W-1:0] cache_q[$];
    logic [W-1:0] buf_q[$];
    int           mode;
    bit           pend_m;
    int           cnt_m;
    logic [1:0]   err_m;
    bit           resp_val;
    logic [W-1:0] resp_data;
    bit           inject_val;
    bit           drop_resp;
    int           rd_seen;
    int           pop_seen;
    logic [63:0]  wrid_seen[$];

    function automatic logic [W-1:0] rand_wqe();
        logic [W-1:0] w;
        for (int i = 0; i < W / 32; i++)
            w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic model_reset();
        cache_q.delete();
        buf_q.delete();
        wrid_seen.delete();
        mode       = M_IDLE;
        pend_m     = 1'b0;
        cnt_m      = 0;
        err_m      = 2'b00;
        resp_val   = 1'b0;
        inject_val = 1'b0;
        drop_resp  = 1'b0;
        rd_seen    = 0;
        pop_seen   = 0;
    endtask

    // One clock: drive inputs on the falling edge, compare every output with the
    // model, let the cache react to the real rd strobe, then advance the model.
    task automatic cycle(input bit en, input bit rdy);
        bit           exp_val;
        bit           exp_pop;
        bit           exp_rd;
        int           owned;
        int           nm;
        logic [W-1:0] head;
        logic [W-1:0] popped;
        @(negedge sys_clk);
        i_en              = en;
        i_wqe_rdy         = rdy;
        i_wqe_cache_empty = (cache_q.size() == 0);
        i_wqe_val         = resp_val | inject_val;
        i_wqe             = resp_val ? resp_data : rand_wqe();
        inject_val        = 1'b0;
        #1;
        exp_val = (buf_q.size() != 0);
        exp_pop = exp_val && rdy;
        owned   = buf_q.size() + int'(pend_m) - int'(exp_pop);
        exp_rd  = (mode == M_RUN) && en && (cache_q.size() != 0) && (owned < 2);

        vectors++;
        if (o_wqe_cache_rd !== exp_rd) begin
            miscompares++;
            $display("[TB] FAIL rd at %0t: got %0b expected %0b", $time, o_wqe_cache_rd, exp_rd);
        end
        vectors++;
        if (o_wqe_val !== exp_val) begin
            miscompares++;
            $display("[TB] FAIL valid at %0t: got %0b expected %0b", $time, o_wqe_val, exp_val);
        end
        if (exp_val) begin
            head = buf_q[0];
            vectors++;
            if (o_wqe !== head) begin
                miscompares++;
                $display("[TB] FAIL head at %0t: got wrid %0h expected wrid %0h", $time, o_wqe[63:0], head[63:0]);
            end
            vectors++;
            if (o_wqe_qpn !== head[QLSB +: QPW] || o_wqe_wrid !== head[63:0]) begin
                miscompares++;
                $display("[TB] FAIL fields at %0t: got qpn %0h wrid %0h expected qpn %0h wrid %0h",
                         $time, o_wqe_qpn, o_wqe_wrid, head[QLSB +: QPW], head[63:0]);
            end
        end
        vectors++;
        if (o_idle !== (mode == M_IDLE)) begin
            miscompares++;
            $display("[TB] FAIL idle at %0t: got %0b expected %0b", $time, o_idle, mode == M_IDLE);
        end
        vectors++;
        if (o_dispatch_cnt !== cnt_m[CW-1:0]) begin
            miscompares++;
            $display("[TB] FAIL count at %0t: got %0d expected %0d", $time, o_dispatch_cnt, cnt_m[CW-1:0]);
        end
        vectors++;
        if (o_err !== err_m) begin
            miscompares++;
            $display("[TB] FAIL err at %0t: got %b expected %b", $time, o_err, err_m);
        end

        if (o_wqe_cache_rd === 1'b1)
            rd_seen++;
        if (o_wqe_val === 1'b1 && rdy) begin
            pop_seen++;
            wrid_seen.push_back(o_wqe[63:0]);
        end

        resp_val = 1'b0;
        if (o_wqe_cache_rd === 1'b1 && cache_q.size() != 0) begin
            popped = cache_q.pop_front();
            if (drop_resp)
                drop_resp = 1'b0;
            else begin
                resp_val  = 1'b1;
                resp_data = popped;
            end
        end

        case (mode)
            M_IDLE:  nm = en ? M_RUN : M_IDLE;
            M_RUN:   nm = en ? M_RUN : M_DRAIN;
            default: nm = en ? M_RUN : ((!pend_m && buf_q.size() == 0) ? M_IDLE : M_DRAIN);
        endcase
        if (i_wqe_val && !pend_m)
            err_m[0] = 1'b1;
        if (pend_m && !i_wqe_val)
            err_m[1] = 1'b1;
        if (exp_pop) begin
            void'(buf_q.pop_front());
            cnt_m++;
        end
        if (i_wqe_val && pend_m)
            buf_q.push_back(i_wqe);
        pend_m = exp_rd;
        mode   = nm;
        @(posedge sys_clk);
        #1;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic apply_reset();
        i_en              = 1'b0;
        i_wqe_rdy         = 1'b0;
        i_wqe_val         = 1'b0;
        i_wqe_cache_empty = 1'b1;
        sys_rst           = 1'b1;
        #1;
        vectors++;
        if (o_wqe_cache_rd !== 1'b0 || o_wqe_val !== 1'b0 || o_idle !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got rd %0b val %0b idle %0b expected 0 0 1", o_wqe_cache_rd, o_wqe_val, o_idle);
        end
        vectors++;
        if (o_dispatch_cnt !== '0 || o_err !== 2'b00 || o_wqe !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got cnt %0d err %b wrid %0h expected 0 00 0", o_dispatch_cnt, o_err, o_wqe[63:0]);
        end
        model_reset();
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (o_idle !== 1'b1 && n < 20) begin
            cycle(1'b0, 1'b1);
            n++;
        end
        vectors++;
        if (o_idle !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s idle timeout: got %0b expected 1", name, o_idle);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 4; i++)
            cache_q.push_back(rand_wqe());
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 1'b1);
        vectors++;
        if (rd_seen != 4 || pop_seen != 4 || o_dispatch_cnt !== 4'd4) begin
            miscompares++;
            $display("[TB] FAIL b2b: got rd %0d pops %0d cnt %0d expected 4 4 4", rd_seen, pop_seen, o_dispatch_cnt);
        end
        wait_idle("b2b");
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w;
        apply_reset();
        for (int i = 1; i <= 3; i++) begin
            w = rand_wqe();
            w[63:0] = 64'(i);
            cache_q.push_back(w);
        end
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 1'b0);
        vectors++;
        if (rd_seen != 2 || o_wqe_val !== 1'b1 || o_wqe_wrid !== 64'd1) begin
            miscompares++;
            $display("[TB] FAIL backpressure: got rd %0d val %0b wrid %0h expected 2 1 1", rd_seen, o_wqe_val, o_wqe_wrid);
        end
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 1'b1);
        vectors++;
        if (wrid_seen.size() != 3) begin
            miscompares++;
            $display("[TB] FAIL bp_count: got %0d expected 3", wrid_seen.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (wrid_seen[i] !== 64'(i + 1)) begin
                    miscompares++;
                    $display("[TB] FAIL bp_order[%0d]: got %0h expected %0h", i, wrid_seen[i], i + 1);
                end
            end
        end
        wait_idle("backpressure");
    endtask

    task automatic test_drain();
        apply_reset();
        for (int i = 0; i < 6; i++)
            cache_q.push_back(rand_wqe());
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b1);
        vectors++;
        if (o_wqe_val !== 1'b1 || pend_m != 1'b1) begin
            miscompares++;
            $display("[TB] FAIL drain_setup: got val %0b pend %0b expected 1 1", o_wqe_val, pend_m);
        end
        rd_seen  = 0;
        pop_seen = 0;
        wait_idle("drain");
        vectors++;
        if (rd_seen != 0 || pop_seen != 2) begin
            miscompares++;
            $display("[TB] FAIL drain: got rd %0d pops %0d expected 0 2", rd_seen, pop_seen);
        end
    endtask

    task automatic test_field_decode();
        logic [W-1:0] w;
        apply_reset();
        w = rand_wqe();
        w[331:328] = 4'h1;
        w[63:0]    = 64'hDEAD_BEEF_0000_0001;
        cache_q.push_back(w);
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b0);
        vectors++;
        if (o_wqe_val !== 1'b1 || o_wqe_qpn !== 4'h1 || o_wqe_wrid !== 64'hDEAD_BEEF_0000_0001) begin
            miscompares++;
            $display("[TB] FAIL decode: got val %0b qpn %0h wrid %0h expected 1 1 deadbeef00000001", o_wqe_val, o_wqe_qpn, o_wqe_wrid);
        end
        wait_idle("decode");
    endtask

    task automatic test_errors();
        apply_reset();
        inject_val = 1'b1;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        vectors++;
        if (o_err !== 2'b01 || o_wqe_val !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_spurious: got err %b val %0b expected 01 0", o_err, o_wqe_val);
        end
        cache_q.push_back(rand_wqe());
        drop_resp = 1'b1;
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b1);
        vectors++;
        if (o_err !== 2'b11 || o_wqe_val !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_missing: got err %b val %0b expected 11 0", o_err, o_wqe_val);
        end
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b1);
        vectors++;
        if (o_err !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL err_sticky: got %b expected 11", o_err);
        end
        apply_reset();
    endtask

    task automatic test_counter_wrap();
        int n = 0;
        apply_reset();
        for (int i = 0; i < 17; i++)
            cache_q.push_back(rand_wqe());
        while (pop_seen < 17 && n < 300) begin
            cycle(1'b1, 1'($urandom_range(0, 3) != 0));
            n++;
        end
        vectors++;
        if (pop_seen != 17 || o_dispatch_cnt !== 4'd1) begin
            miscompares++;
            $display("[TB] FAIL wrap: got pops %0d cnt %0d expected 17 1", pop_seen, o_dispatch_cnt);
        end
        for (int i = 0; i < 6; i++)
            cache_q.push_back(rand_wqe());
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b0);
        #2;
        apply_reset();
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1);
    endtask

    task automatic test_random();
        bit en;
        apply_reset();
        en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0)
                en = ~en;
            if ($urandom_range(0, 2) == 0)
                cache_q.push_back(rand_wqe());
            cycle(en, 1'($urandom_range(0, 2) != 0));
        end
        wait_idle("random");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        sys_rst     = 1'b1;
        i_en        = 1'b0;
        i_wqe_rdy   = 1'b0;
        i_wqe_val   = 1'b0;
        i_wqe       = '0;
        i_wqe_cache_empty = 1'b1;
        model_reset();
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_drain();
        test_field_decode();
        test_errors();
        test_counter_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
